// File: rtl/if_stage_fetch_unit_if.sv
// Instruction-memory request channel between the fetch stage (master) and imem (slave).
interface if_stage_fetch_unit_if #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned INSTR_W = 32
);
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ready;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/if_stage_fetch_unit.sv
// Instruction-fetch stage with IF/ID register, freeze hold buffer and branch redirect.
// Optional FETCH_STATS_EN adds saturating freeze/flush event counters.
module if_stage_fetch_unit #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INSTR_W  = 32,
  parameter int unsigned       PC_STEP  = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               freeze,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_addr,
  if_stage_fetch_unit_if.master imem,
  output logic               if_valid,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [INSTR_W-1:0] if_instr
`ifdef FETCH_STATS_EN
  ,
  output logic [15:0]        stat_freeze_cnt,
  output logic [15:0]        stat_flush_cnt
`endif
);

  typedef enum logic [0:0] {
    S_FETCH = 1'b0,
    S_HOLD  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  hold_pc_q, hold_pc_d;
  logic [INSTR_W-1:0] hold_instr_q, hold_instr_d;
  logic               if_valid_q, if_valid_d;
  logic [ADDR_W-1:0]  if_pc_q, if_pc_d;
  logic [INSTR_W-1:0] if_instr_q, if_instr_d;
  logic [ADDR_W-1:0]  pc_next;

  assign pc_next        = pc_q + ADDR_W'(PC_STEP);
  assign imem.imem_req  = (state_q == S_FETCH);
  assign imem.imem_addr = pc_q;
  assign if_valid       = if_valid_q;
  assign if_pc          = if_pc_q;
  assign if_instr       = if_instr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      hold_pc_q    <= '0;
      hold_instr_q <= '0;
      if_valid_q   <= 1'b0;
      if_pc_q      <= '0;
      if_instr_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      hold_pc_q    <= hold_pc_d;
      hold_instr_q <= hold_instr_d;
      if_valid_q   <= if_valid_d;
      if_pc_q      <= if_pc_d;
      if_instr_q   <= if_instr_d;
    end
  end

  // Branch redirect overrides freeze; a beat arriving under freeze parks in the hold buffer.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    hold_pc_d    = hold_pc_q;
    hold_instr_d = hold_instr_q;
    if_valid_d   = if_valid_q;
    if_pc_d      = if_pc_q;
    if_instr_d   = if_instr_q;

    if (branch_taken) begin
      state_d      = S_FETCH;
      pc_d         = branch_addr;
      if_valid_d   = 1'b0;
      hold_pc_d    = '0;
      hold_instr_d = '0;
    end else begin
      unique case (state_q)
        S_FETCH: begin
          if (imem.imem_ready) begin
            pc_d = pc_next;
            if (freeze) begin
              hold_pc_d    = pc_next;
              hold_instr_d = imem.imem_rdata;
              state_d      = S_HOLD;
            end else begin
              if_valid_d = 1'b1;
              if_pc_d    = pc_next;
              if_instr_d = imem.imem_rdata;
            end
          end else if (!freeze) begin
            if_valid_d = 1'b0;
          end
        end
        S_HOLD: begin
          if (!freeze) begin
            if_valid_d   = 1'b1;
            if_pc_d      = hold_pc_q;
            if_instr_d   = hold_instr_q;
            hold_pc_d    = '0;
            hold_instr_d = '0;
            state_d      = S_FETCH;
          end
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

`ifdef FETCH_STATS_EN
  logic [15:0] freeze_cnt_q, freeze_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    freeze_cnt_d = freeze_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (freeze && !branch_taken && (freeze_cnt_q != 16'hFFFF)) begin
      freeze_cnt_d = freeze_cnt_q + 16'd1;
    end
    if (branch_taken && (flush_cnt_q != 16'hFFFF)) begin
      flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      freeze_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      freeze_cnt_q <= freeze_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign stat_freeze_cnt = freeze_cnt_q;
  assign stat_flush_cnt  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_stage_fetch_unit.sv
// Directed self-checking bench for if_stage_fetch_unit; memory answers rdata = addr ^ 32'hA5A5_0000.
module tb_if_stage_fetch_unit;

  localparam logic [31:0] K = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = '0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
`ifdef FETCH_STATS_EN
  logic [15:0] stat_freeze_cnt;
  logic [15:0] stat_flush_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  if_stage_fetch_unit_if #(.ADDR_W(32), .INSTR_W(32)) imem ();

  assign imem.imem_rdata = imem.imem_addr ^ K;

  if_stage_fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem         (imem.master),
    .if_valid     (if_valid),
    .if_pc        (if_pc),
    .if_instr     (if_instr)
`ifdef FETCH_STATS_EN
    ,
    .stat_freeze_cnt (stat_freeze_cnt),
    .stat_flush_cnt  (stat_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    imem.imem_ready = 1'b0;
    tick();
    tick();
    if ({if_valid, if_pc, if_instr} !== {1'b0, 32'h0, 32'h0}) begin
      $display("FAIL reset_ifid got=%h exp=%h", {if_valid, if_pc, if_instr}, {1'b0, 64'h0});
      miscompares++;
    end
    vectors++;
    rst = 1'b0;
    if ({imem.imem_req, imem.imem_addr} !== {1'b1, 32'h0}) begin
      $display("FAIL reset_req got=%h exp=%h", {imem.imem_req, imem.imem_addr}, {1'b1, 32'h0});
      miscompares++;
    end
    vectors++;
  endtask

  task automatic test_stream();
    logic [31:0] a;
    imem.imem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = 32'(4 * i);
      if ({imem.imem_req, imem.imem_addr} !== {1'b1, a}) begin
        $display("FAIL stream_addr%0d got=%h exp=%h", i, {imem.imem_req, imem.imem_addr}, {1'b1, a});
        miscompares++;
      end
      vectors++;
      tick();
      if ({if_valid, if_pc, if_instr} !== {1'b1, a + 32'd4, a ^ K}) begin
        $display("FAIL stream_ifid%0d got=%h exp=%h", i, {if_valid, if_pc, if_instr}, {1'b1, a + 32'd4, a ^ K});
        miscompares++;
      end
      vectors++;
    end
  endtask

  task automatic test_latency();
    imem.imem_ready = 1'b0;
    for (int j = 0; j < 2; j++) begin
      tick();
      if ({if_valid, imem.imem_req, imem.imem_addr} !== {1'b0, 1'b1, 32'd16}) begin
        $display("FAIL latency_wait%0d got=%h exp=%h", j, {if_valid, imem.imem_req, imem.imem_addr}, {2'b01, 32'd16});
        miscompares++;
      end
      vectors++;
    end
    imem.imem_ready = 1'b1;
    tick();
    if ({if_valid, if_pc, if_instr, imem.imem_addr} !== {1'b1, 32'd20, 32'hA5A5_0010, 32'd20}) begin
      $display("FAIL latency_beat got=%h exp=%h", {if_valid, if_pc, if_instr, imem.imem_addr}, {1'b1, 32'd20, 32'hA5A5_0010, 32'd20});
      miscompares++;
    end
    vectors++;
    imem.imem_ready = 1'b0;
  endtask

  task automatic test_freeze();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    imem.imem_ready = 1'b1;
    tick();
    tick();
    freeze = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick();
      if ({if_valid, if_pc, if_instr, imem.imem_req, imem.imem_addr} !== {1'b1, 32'd8, 32'hA5A5_0004, 1'b0, 32'd12}) begin
        $display("FAIL freeze_hold%0d got=%h exp=%h", j, {if_valid, if_pc, if_instr, imem.imem_req, imem.imem_addr}, {1'b1, 32'd8, 32'hA5A5_0004, 1'b0, 32'd12});
        miscompares++;
      end
      vectors++;
    end
    freeze = 1'b0;
    tick();
    if ({if_valid, if_pc, if_instr, imem.imem_req, imem.imem_addr} !== {1'b1, 32'd12, 32'hA5A5_0008, 1'b1, 32'd12}) begin
      $display("FAIL freeze_release got=%h exp=%h", {if_valid, if_pc, if_instr, imem.imem_req, imem.imem_addr}, {1'b1, 32'd12, 32'hA5A5_0008, 1'b1, 32'd12});
      miscompares++;
    end
    vectors++;
    tick();
    if ({if_valid, if_pc, if_instr} !== {1'b1, 32'd16, 32'hA5A5_000C}) begin
      $display("FAIL freeze_resume got=%h exp=%h", {if_valid, if_pc, if_instr}, {1'b1, 32'd16, 32'hA5A5_000C});
      miscompares++;
    end
    vectors++;
    imem.imem_ready = 1'b0;
    freeze = 1'b1;
    tick();
    if ({if_valid, if_pc, if_instr, imem.imem_req, imem.imem_addr} !== {1'b1, 32'd16, 32'hA5A5_000C, 1'b1, 32'd16}) begin
      $display("FAIL freeze_noready got=%h exp=%h", {if_valid, if_pc, if_instr, imem.imem_req, imem.imem_addr}, {1'b1, 32'd16, 32'hA5A5_000C, 1'b1, 32'd16});
      miscompares++;
    end
    vectors++;
    freeze = 1'b0;
    tick();
    if ({if_valid, imem.imem_req, imem.imem_addr} !== {1'b0, 1'b1, 32'd16}) begin
      $display("FAIL freeze_bubble got=%h exp=%h", {if_valid, imem.imem_req, imem.imem_addr}, {2'b01, 32'd16});
      miscompares++;
    end
    vectors++;
  endtask

  task automatic test_branch();
    branch_taken = 1'b1;
    branch_addr = 32'h100;
    freeze = 1'b1;
    imem.imem_ready = 1'b1;
    tick();
    if ({if_valid, imem.imem_req, imem.imem_addr} !== {1'b0, 1'b1, 32'h100}) begin
      $display("FAIL branch_flush got=%h exp=%h", {if_valid, imem.imem_req, imem.imem_addr}, {2'b01, 32'h100});
      miscompares++;
    end
    vectors++;
    branch_taken = 1'b0;
    freeze = 1'b0;
    tick();
    if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h104, 32'hA5A5_0100}) begin
      $display("FAIL branch_target got=%h exp=%h", {if_valid, if_pc, if_instr}, {1'b1, 32'h104, 32'hA5A5_0100});
      miscompares++;
    end
    vectors++;
    freeze = 1'b1;
    tick();
    branch_taken = 1'b1;
    branch_addr = 32'h203;
    tick();
    if ({if_valid, imem.imem_req, imem.imem_addr} !== {1'b0, 1'b1, 32'h203}) begin
      $display("FAIL branch_from_hold got=%h exp=%h", {if_valid, imem.imem_req, imem.imem_addr}, {2'b01, 32'h203});
      miscompares++;
    end
    vectors++;
    branch_taken = 1'b0;
    freeze = 1'b0;
    tick();
    if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h207, 32'hA5A5_0203}) begin
      $display("FAIL branch_unaligned got=%h exp=%h", {if_valid, if_pc, if_instr}, {1'b1, 32'h207, 32'hA5A5_0203});
      miscompares++;
    end
    vectors++;
  endtask

  task automatic test_wrap_and_reset();
    branch_taken = 1'b1;
    branch_addr = 32'hFFFF_FFFC;
    imem.imem_ready = 1'b0;
    tick();
    branch_taken = 1'b0;
    imem.imem_ready = 1'b1;
    tick();
    if ({if_valid, if_pc, if_instr, imem.imem_addr} !== {1'b1, 32'h0, 32'h5A5A_FFFC, 32'h0}) begin
      $display("FAIL wrap got=%h exp=%h", {if_valid, if_pc, if_instr, imem.imem_addr}, {1'b1, 32'h0, 32'h5A5A_FFFC, 32'h0});
      miscompares++;
    end
    vectors++;
    tick();
    imem.imem_ready = 1'b0;
    tick();
    tick();
    if ({imem.imem_req, imem.imem_addr} !== {1'b1, 32'h4}) begin
      $display("FAIL wait_addr got=%h exp=%h", {imem.imem_req, imem.imem_addr}, {1'b1, 32'h4});
      miscompares++;
    end
    vectors++;
    rst = 1'b1;
    imem.imem_ready = 1'b1;
    tick();
    rst = 1'b0;
    if ({if_valid, if_pc, if_instr, imem.imem_req, imem.imem_addr} !== {1'b0, 64'h0, 1'b1, 32'h0}) begin
      $display("FAIL midreset got=%h exp=%h", {if_valid, if_pc, if_instr, imem.imem_req, imem.imem_addr}, {1'b0, 64'h0, 1'b1, 32'h0});
      miscompares++;
    end
    vectors++;
    tick();
    if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h4, K}) begin
      $display("FAIL post_reset_fetch got=%h exp=%h", {if_valid, if_pc, if_instr}, {1'b1, 32'h4, K});
      miscompares++;
    end
    vectors++;
    imem.imem_ready = 1'b0;
  endtask

`ifdef FETCH_STATS_EN
  task automatic test_stats();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    freeze = 1'b1;
    repeat (5) tick();
    freeze = 1'b0;
    branch_taken = 1'b1;
    repeat (2) tick();
    branch_taken = 1'b0;
    if ({stat_freeze_cnt, stat_flush_cnt} !== {16'd5, 16'd2}) begin
      $display("FAIL stats_count got=%h exp=%h", {stat_freeze_cnt, stat_flush_cnt}, {16'd5, 16'd2});
      miscompares++;
    end
    vectors++;
    freeze = 1'b1;
    repeat (70000) tick();
    if (stat_freeze_cnt !== 16'hFFFF) begin
      $display("FAIL stats_saturate got=%h exp=%h", stat_freeze_cnt, 16'hFFFF);
      miscompares++;
    end
    vectors++;
    freeze = 1'b0;
  endtask
`endif

  initial begin
    imem.imem_ready = 1'b0;
    test_reset();
    test_stream();
    test_latency();
    test_freeze();
    test_branch();
    test_wrap_and_reset();
`ifdef FETCH_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
